// File: rtl/placement_pkg.sv
// Constants shared by the placer FSM and the cost evaluator: state encoding, default widths
// and the UNPLACED marker written into pos_X/pos_Y for nodes the placer has not assigned.
package placement_pkg;
  localparam int DW_DEF     = 32;
  localparam int AW_DEF     = 32;
  localparam int N_EDGE_DEF = 22;
  localparam int UNPLACED   = -1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_CHK, S_RD_E, S_W_E, S_RD_A, S_W_A, S_LAT_A,
    S_RD_B, S_W_B, S_LAT_B, S_DIFF, S_ABS, S_ACC, S_FIN
  } eval_state_t;
endpackage

// File: rtl/placement_cost_eval_dist_unit.sv
// dist_unit: combinational per-edge distance terms from two endpoint positions.
// The Chebyshev term exists only when CHEB_COST_EN is defined.
module dist_unit
  import placement_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] i_ax,
  input  logic [DW-1:0] i_ay,
  input  logic [DW-1:0] i_bx,
  input  logic [DW-1:0] i_by,
  output logic [DW-1:0] o_adx,
  output logic [DW-1:0] o_ady,
  output logic [DW-1:0] o_hop
`ifdef CHEB_COST_EN
  ,
  output logic [DW-1:0] o_cheb
`endif
);
  localparam logic [DW-1:0] ONE = DW'(1);

  logic [DW-1:0] w_dx, w_dy;

  assign w_dx  = i_ax - i_bx;
  assign w_dy  = i_ay - i_by;
  assign o_adx = w_dx[DW-1] ? (~w_dx + ONE) : w_dx;
  assign o_ady = w_dy[DW-1] ? (~w_dy + ONE) : w_dy;

  // ceil(|d|/2) as (|d|>>1) + lsb, one per axis, minus one hop for the edge itself
  assign o_hop = (o_adx >> 1) + {{(DW-1){1'b0}}, o_adx[0]}
               + (o_ady >> 1) + {{(DW-1){1'b0}}, o_ady[0]} - ONE;

`ifdef CHEB_COST_EN
  assign o_cheb = ((o_adx > o_ady) ? o_adx : o_ady) - ONE;
`endif
endmodule

// File: rtl/placement_cost_eval.sv
// Walks the EA/EB edge ROMs, fetches both endpoints from pos_X/pos_Y and accumulates wirelength.
// Optional Chebyshev sum (o_sum_cheb) is built only when CHEB_COST_EN is defined.
module placement_cost_eval
  import placement_pkg::*;
#(
  parameter int N_EDGE = N_EDGE_DEF,
  parameter int DW     = DW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic          o_edge_re,
  output logic [AW-1:0] o_edge_addr,
  input  logic [DW-1:0] i_edge_a,
  input  logic [DW-1:0] i_edge_b,
  output logic          o_pos_re,
  output logic [AW-1:0] o_pos_addr,
  input  logic [DW-1:0] i_pos_x,
  input  logic [DW-1:0] i_pos_y,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_unplaced,
  output logic [DW-1:0] o_sum_cost,
  output logic [DW-1:0] o_sum_1hop
`ifdef CHEB_COST_EN
  ,
  output logic [DW-1:0] o_sum_cheb
`endif
);
  localparam logic [AW-1:0] N_LAST = AW'(N_EDGE);
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] UNP    = DW'(UNPLACED);

  eval_state_t   r_state, w_next;
  logic [AW-1:0] r_idx, r_edge_addr, r_pos_addr, w_edge_addr, w_pos_addr;
  logic          r_edge_re, r_pos_re, r_busy, r_done, r_unpl, r_skip;
  logic          w_edge_re, w_pos_re, w_busy, w_done, w_skip, w_last;
  logic [DW-1:0] r_ea, r_eb, r_ax, r_ay, r_bx, r_by;
  logic [DW-1:0] r_adx, r_ady, r_tc, r_th, r_sc, r_sh;
  logic [DW-1:0] w_adx, w_ady, w_hop;
`ifdef CHEB_COST_EN
  logic [DW-1:0] w_cheb, r_tv, r_sv;
`endif

  dist_unit #(.DW(DW)) u_dist (
    .i_ax (r_ax),
    .i_ay (r_ay),
    .i_bx (r_bx),
    .i_by (r_by),
    .o_adx(w_adx),
    .o_ady(w_ady),
    .o_hop(w_hop)
`ifdef CHEB_COST_EN
    ,
    .o_cheb(w_cheb)
`endif
  );

  assign w_last = ((r_idx + A_ONE) == N_LAST);
  assign w_skip = (r_ax == UNP) || (r_ay == UNP) || (r_bx == UNP) || (r_by == UNP);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // ACC takes the loop decision itself so each edge costs 11 cycles; CHK only guards the first edge.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_start) w_next = S_CLR;
      S_CLR:   w_next = S_CHK;
      S_CHK:   w_next = (r_idx == N_LAST) ? S_FIN : S_RD_E;
      S_RD_E:  w_next = S_W_E;
      S_W_E:   w_next = S_RD_A;
      S_RD_A:  w_next = S_W_A;
      S_W_A:   w_next = S_LAT_A;
      S_LAT_A: w_next = S_RD_B;
      S_RD_B:  w_next = S_W_B;
      S_W_B:   w_next = S_LAT_B;
      S_LAT_B: w_next = S_DIFF;
      S_DIFF:  w_next = S_ABS;
      S_ABS:   w_next = S_ACC;
      S_ACC:   w_next = w_last ? S_FIN : S_RD_E;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes and addresses are decoded from the next state and registered, so each read
  // strobe is a clean one-cycle pulse coincident with its RD_* state.
  always_comb begin
    w_edge_re   = (w_next == S_RD_E);
    w_pos_re    = (w_next == S_RD_A) || (w_next == S_RD_B);
    w_busy      = (w_next != S_IDLE) && (w_next != S_FIN);
    w_done      = (w_next == S_FIN);
    w_edge_addr = (r_state == S_ACC) ? (r_idx + A_ONE) : r_idx;
    w_pos_addr  = (r_state == S_W_E) ? AW'(i_edge_a) : AW'(r_eb);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_edge_re   <= 1'b0;
      r_pos_re    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_edge_addr <= '0;
      r_pos_addr  <= '0;
    end else begin
      r_edge_re <= w_edge_re;
      r_pos_re  <= w_pos_re;
      r_busy    <= w_busy;
      r_done    <= w_done;
      if (w_edge_re) r_edge_addr <= w_edge_addr;
      if (w_pos_re)  r_pos_addr  <= w_pos_addr;
    end
  end

  // Read data is only valid in the W_* cycle, so everything is captured there.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_idx  <= '0;
      r_unpl <= 1'b0;
      r_skip <= 1'b0;
      r_sc   <= '0;
      r_sh   <= '0;
      r_ea   <= '0;
      r_eb   <= '0;
      r_ax   <= '0;
      r_ay   <= '0;
      r_bx   <= '0;
      r_by   <= '0;
      r_adx  <= '0;
      r_ady  <= '0;
      r_tc   <= '0;
      r_th   <= '0;
`ifdef CHEB_COST_EN
      r_tv   <= '0;
      r_sv   <= '0;
`endif
    end else begin
      unique case (r_state)
        S_CLR: begin
          r_idx  <= '0;
          r_unpl <= 1'b0;
          r_sc   <= '0;
          r_sh   <= '0;
`ifdef CHEB_COST_EN
          r_sv   <= '0;
`endif
        end
        S_W_E: begin
          r_ea <= i_edge_a;
          r_eb <= i_edge_b;
        end
        S_W_A: begin
          r_ax <= i_pos_x;
          r_ay <= i_pos_y;
        end
        S_W_B: begin
          r_bx <= i_pos_x;
          r_by <= i_pos_y;
        end
        S_DIFF: begin
          r_adx  <= w_adx;
          r_ady  <= w_ady;
          r_skip <= w_skip;
          if (w_skip) r_unpl <= 1'b1;
        end
        S_ABS: begin
          r_tc <= r_adx + r_ady - D_ONE;
          r_th <= w_hop;
`ifdef CHEB_COST_EN
          r_tv <= w_cheb;
`endif
        end
        S_ACC: begin
          r_idx <= r_idx + A_ONE;
          if (!r_skip) begin
            r_sc <= r_sc + r_tc;
            r_sh <= r_sh + r_th;
`ifdef CHEB_COST_EN
            r_sv <= r_sv + r_tv;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign o_edge_re   = r_edge_re;
  assign o_edge_addr = r_edge_addr;
  assign o_pos_re    = r_pos_re;
  assign o_pos_addr  = r_pos_addr;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_unplaced  = r_unpl;
  assign o_sum_cost  = r_sc;
  assign o_sum_1hop  = r_sh;
`ifdef CHEB_COST_EN
  assign o_sum_cheb  = r_sv;
`endif
endmodule
